case6_preimage_search: RTL and testbench

CASE6_PREIMAGE_SEARCH -- requirements
Module: case6_preimage_search

---
 rtl/case6_preimage_search.sv | 154 +++++++++++++++
 tb/tb_case6_preimage_search.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/case6_preimage_search.sv
// case6_preimage_search
// Scans all 64 input vectors {a,b,c,d,e,f} of the case6 function in
// ascending order and hands off every vector whose output {y1,y2,y3}
// equals a latched target, one at a time, through a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   start        one-cycle search request, honoured only in IDLE
//   target[2:0]  required {y1,y2,y3}, latched when start is accepted
//   abort        abandon the running search (no done pulse)
//   out_ready    consumer accepts the presented match
//   busy         high while scanning or holding a match
//   match_valid  high while a match is presented
//   match_vec    presented preimage {a,b,c,d,e,f}, a is MSB
//   match_count  matches handed off in the current/last search (0..64)
//   done         one-cycle pulse when a search completes normally
module case6_preimage_search (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] target,
    input  logic       abort,
    input  logic       out_ready,
    output logic       busy,
    output logic       match_valid,
    output logic [5:0] match_vec,
    output logic [6:0] match_count,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // case6: x=e^f; y3=x&~c&~d; y2=x|~(a&b); y1=y2&~y3; result {y1,y2,y3}
    function automatic logic [2:0] case6_eval(input logic [5:0] v);
        logic x;
        logic y1;
        logic y2;
        logic y3;
        x  = v[1] ^ v[0];
        y3 = x & ~v[3] & ~v[2];
        y2 = x | ~(v[5] & v[4]);
        y1 = y2 & ~y3;
        return {y1, y2, y3};
    endfunction

    state_t     state_r;
    logic [5:0] idx_r;
    logic [2:0] target_r;
    logic       busy_r;
    logic       match_valid_r;
    logic [5:0] match_vec_r;
    logic [6:0] match_count_r;
    logic       done_r;
    logic [2:0] f_s;

    // Function value of the vector currently being examined.
    always_comb begin
        f_s = case6_eval(idx_r);
    end

    // Search FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            idx_r         <= 6'd0;
            target_r      <= 3'd0;
            busy_r        <= 1'b0;
            match_valid_r <= 1'b0;
            match_vec_r   <= 6'd0;
            match_count_r <= 7'd0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        target_r      <= target;
                        idx_r         <= 6'd0;
                        match_count_r <= 7'd0;
                        busy_r        <= 1'b1;
                        state_r       <= ST_SCAN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (f_s == target_r) begin
                        // idx stays put so HOLD knows where to resume
                        match_vec_r   <= idx_r;
                        match_valid_r <= 1'b1;
                        state_r       <= ST_HOLD;
                    end else if (idx_r == 6'd63) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + 6'd1;
                    end
                end
                ST_HOLD: begin
                    // abort beats out_ready: the pending match is not counted
                    if (abort) begin
                        match_valid_r <= 1'b0;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else if (out_ready) begin
                        match_valid_r <= 1'b0;
                        if (match_count_r < 7'd64) begin
                            match_count_r <= match_count_r + 7'd1;
                        end else begin
                            match_count_r <= 7'd64;
                        end
                        if (idx_r == 6'd63) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            idx_r   <= idx_r + 6'd1;
                            state_r <= ST_SCAN;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r        <= 1'b0;
                    match_valid_r <= 1'b0;
                    done_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign match_valid = match_valid_r;
    assign match_vec   = match_vec_r;
    assign match_count = match_count_r;
    assign done        = done_r;

endmodule

// File: tb/tb_case6_preimage_search.sv
module tb_case6_preimage_search;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] target;
    logic       abort;
    logic       out_ready;
    logic       busy;
    logic       match_valid;
    logic [5:0] match_vec;
    logic [6:0] match_count;
    logic       done;

    int n_pass;
    int n_total;

    case6_preimage_search dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .target      (target),
        .abort       (abort),
        .out_ready   (out_ready),
        .busy        (busy),
        .match_valid (match_valid),
        .match_vec   (match_vec),
        .match_count (match_count),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] tgt;
        int         count;
        int         first_v;
        int         last_v;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: evaluate the boolean equations on the bits of i.
    function automatic int f_ref(input int i);
        int a, b, c, d, e, f, x, y1, y2, y3;
        a = (i >> 5) & 1; b = (i >> 4) & 1; c = (i >> 3) & 1;
        d = (i >> 2) & 1; e = (i >> 1) & 1; f = i & 1;
        x  = (e != f) ? 1 : 0;
        y3 = (x == 1 && c == 0 && d == 0) ? 1 : 0;
        y2 = (x == 1 || !(a == 1 && b == 1)) ? 1 : 0;
        y1 = (y2 == 1 && y3 == 0) ? 1 : 0;
        return y1 * 4 + y2 * 2 + y3;
    endfunction

    // One search. ready_pct: chance of out_ready per cycle; stall_n: cycles
    // out_ready is withheld on the first match; abort_n >= 0 aborts while
    // match number abort_n is presented; rand_start fires start while busy.
    task automatic run_search(input logic [2:0] tgt, input int ready_pct,
                              input int stall_n, input int abort_n,
                              input bit rand_start, output int n_got,
                              output int first_v, output int last_v,
                              output int done_cyc);
        int exp_q[$];
        int got_q[$];
        int cyc, done_cnt, stall_cnt, bad, late_done;
        bit stall_ok, stable_ok, aborted, prev_hold;
        logic [5:0] prev_vec;
        for (int i = 0; i < 64; i++) if (f_ref(i) == int'(tgt)) exp_q.push_back(i);
        @(negedge clk);
        start = 1'b1; target = tgt; out_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        start = 1'b0; target = 3'($urandom);
        cyc = 1; done_cnt = 0; done_cyc = -1; stall_cnt = 0;
        stall_ok = 1'b1; stable_ok = 1'b1; aborted = 1'b0; prev_hold = 1'b0;
        prev_vec = 6'd0;
        while (cyc < 1000) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                break;
            end
            if (prev_hold && (!match_valid || match_vec !== prev_vec)) stable_ok = 1'b0;
            out_ready = ($urandom_range(0, 99) < ready_pct) ? 1'b1 : 1'b0;
            abort = 1'b0;
            start = 1'b0;
            prev_hold = 1'b0;
            if (match_valid) begin
                if (got_q.size() == 0 && stall_cnt < stall_n) begin
                    out_ready = 1'b0;
                    if (exp_q.size() == 0 || int'(match_vec) != exp_q[0]) stall_ok = 1'b0;
                    stall_cnt++;
                end
                if (abort_n >= 0 && got_q.size() == abort_n) begin
                    abort = 1'b1;
                    out_ready = 1'b1;
                    aborted = 1'b1;
                end else if (out_ready) begin
                    got_q.push_back(int'(match_vec));
                end else begin
                    prev_hold = 1'b1;
                    prev_vec = match_vec;
                end
            end
            if (rand_start && busy && $urandom_range(0, 9) == 0) begin
                start = 1'b1;
                target = 3'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (aborted) break;
        end
        abort = 1'b0; out_ready = 1'b0; start = 1'b0;
        n_got = got_q.size();
        first_v = (got_q.size() > 0) ? got_q[0] : -1;
        last_v = (got_q.size() > 0) ? got_q[got_q.size() - 1] : -1;
        check("hold_stable", int'(stable_ok), 1);
        if (stall_n > 0) begin
            check("stall_vec_stable", int'(stall_ok), 1);
            check("stall_cycles", stall_cnt, stall_n);
        end
        if (abort_n >= 0) begin
            check("abort_seen", int'(aborted), 1);
            check("abort_busy", int'(busy), 0);
            check("abort_valid", int'(match_valid), 0);
            check("abort_count", int'(match_count), abort_n);
            late_done = 0;
            for (int k = 0; k < 5; k++) begin
                if (done || busy) late_done++;
                @(negedge clk);
            end
            check("abort_no_done", late_done, 0);
            check("abort_count_hold", int'(match_count), abort_n);
        end else begin
            check("done_pulse", done_cnt, 1);
            check("match_total", got_q.size(), exp_q.size());
            bad = 0;
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
                if (got_q[k] != exp_q[k]) bad++;
            check("match_order", bad, 0);
            check("match_count", int'(match_count), exp_q.size());
            // done in DONE state; start here must be ignored too
            start = rand_start;
            target = 3'($urandom);
            @(negedge clk);
            start = 1'b0;
            check("done_one_cycle", int'(done), 0);
            check("idle_after_done", int'(busy), 0);
            check("count_holds", int'(match_count), exp_q.size());
        end
    endtask

    vec_t tbl[8];
    int n_got, first_v, last_v, done_cyc, sum_cnt, rc, rt;
    logic [2:0] rtgt;

    initial begin
        n_pass = 0; n_total = 0;
        tbl[0] = '{3'b111, 0, -1, -1};
        tbl[1] = '{3'b011, 8, 1, 50};
        tbl[2] = '{3'b000, 8, 48, 63};
        tbl[3] = '{3'b110, 48, 0, 62};
        tbl[4] = '{3'b001, 0, -1, -1};
        tbl[5] = '{3'b010, 0, -1, -1};
        tbl[6] = '{3'b100, 0, -1, -1};
        tbl[7] = '{3'b101, 0, -1, -1};

        // reset with start and abort also high: reset wins
        rst = 1'b1; start = 1'b1; abort = 1'b1; target = 3'b110; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(match_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_vec", int'(match_vec), 0);
        check("rst_count", int'(match_count), 0);

        // table: every target with out_ready held high
        sum_cnt = 0;
        for (int t = 0; t < 8; t++) begin
            run_search(tbl[t].tgt, 100, 0, -1, 1'b0, n_got, first_v, last_v, done_cyc);
            check("tbl_count", n_got, tbl[t].count);
            check("tbl_latency", done_cyc, 65 + tbl[t].count);
            if (tbl[t].count > 0) begin
                check("tbl_first", first_v, tbl[t].first_v);
                check("tbl_last", last_v, tbl[t].last_v);
            end
            sum_cnt += n_got;
        end
        check("sum_all_targets", sum_cnt, 64);

        // first match withheld for 10 cycles
        run_search(3'b011, 100, 10, -1, 1'b0, n_got, first_v, last_v, done_cyc);
        check("stall_total", n_got, 8);
        check("stall_latency", done_cyc, 65 + 8 + 10);

        // abort while the 4th match is held, with out_ready also high
        run_search(3'b110, 60, 0, 3, 1'b0, n_got, first_v, last_v, done_cyc);

        // reset mid-SCAN (no-match target keeps it scanning)
        @(negedge clk);
        start = 1'b1; target = 3'b111;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("scan_busy", int'(busy), 1);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_count", int'(match_count), 0);
        rc = 0;
        for (int k = 0; k < 70; k++) begin
            if (done || busy) rc++;
            @(negedge clk);
        end
        check("midrst_no_done", rc, 0);

        // randomized searches with stalls, ignored starts and target changes
        for (int r = 0; r < 12; r++) begin
            rtgt = 3'($urandom);
            rt = $urandom_range(0, 99);
            if (rt < 40) rtgt = 3'b110;
            else if (rt < 60) rtgt = 3'b011;
            else if (rt < 80) rtgt = 3'b000;
            run_search(rtgt, int'($urandom_range(30, 100)), int'($urandom_range(0, 3)),
                       -1, 1'b1, n_got, first_v, last_v, done_cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
